// File: rtl/temp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temp_pkg
// Brief    : Shared types and constants for the temperature BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
package temp_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int BCD_MAX    = 999;
  localparam int NUM_DIGITS = 3;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble digit correction, adds 3 to any digit >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd5) ? (in + 4'd3) : in;

endmodule
`default_nettype wire

// File: rtl/temp_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : temp_bcd_conv
// Brief    : Sequential signed-binary to sign + 3-digit BCD converter
//            (shift-and-add-3). Saturation at 999 is built only when
//            TEMP_CONV_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module temp_bcd_conv
  import temp_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic [3:0]   temp_value_ones,
  output logic [3:0]   temp_value_tens,
  output logic [3:0]   temp_value_huns,
  output logic         temp_value_sign,
  output logic         ovf
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = 4 * NUM_DIGITS;

  conv_state_t     r_state;
  logic [W-1:0]    r_sample;
  logic [W-1:0]    r_mag;
  logic [SW-1:0]   r_scratch;
  logic [CW-1:0]   r_count;
  logic            r_sign;
  logic [W-1:0]    w_abs;
  logic [SW-1:0]   w_adj;

  // Negating -2^(W-1) wraps to itself, which reads correctly as unsigned 2^(W-1)
  assign w_abs = r_sample[W-1] ? (-r_sample) : r_sample;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_add3 u_add3 (
      .in  (r_scratch[4*gi +: 4]),
      .out (w_adj[4*gi +: 4])
    );
  end

`ifdef TEMP_CONV_SAT_EN
  logic r_over;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_sample        <= '0;
      r_mag           <= '0;
      r_scratch       <= '0;
      r_count         <= '0;
      r_sign          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      temp_value_ones <= '0;
      temp_value_tens <= '0;
      temp_value_huns <= '0;
      temp_value_sign <= 1'b0;
`ifdef TEMP_CONV_SAT_EN
      r_over          <= 1'b0;
      ovf             <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            r_sample <= value;
            r_state  <= ABS;
          end
        end
        ABS: begin
          busy      <= 1'b1;
          // A negative sample is never zero, so the MSB alone gives a sign without negative zero
          r_sign    <= r_sample[W-1];
          r_mag     <= w_abs;
          r_scratch <= '0;
          r_count   <= CW'(W);
`ifdef TEMP_CONV_SAT_EN
          r_over    <= (32'(w_abs) > 32'(BCD_MAX));
`endif
          r_state   <= SHIFT;
        end
        SHIFT: begin
          // Carry out of the hundreds digit falls off, leaving magnitude mod 1000
          r_scratch <= {w_adj[SW-2:0], r_mag[W-1]};
          r_mag     <= {r_mag[W-2:0], 1'b0};
          r_count   <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          done            <= 1'b1;
          temp_value_sign <= r_sign;
`ifdef TEMP_CONV_SAT_EN
          ovf             <= r_over;
          if (r_over) begin
            temp_value_huns <= 4'd9;
            temp_value_tens <= 4'd9;
            temp_value_ones <= 4'd9;
          end else begin
            temp_value_huns <= r_scratch[11:8];
            temp_value_tens <= r_scratch[7:4];
            temp_value_ones <= r_scratch[3:0];
          end
`else
          temp_value_huns <= r_scratch[11:8];
          temp_value_tens <= r_scratch[7:4];
          temp_value_ones <= r_scratch[3:0];
`endif
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_temp_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_bcd_conv
// Brief    : Self-checking bench for temp_bcd_conv against a decimal
//            arithmetic reference; honours TEMP_CONV_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_bcd_conv;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic [3:0]   temp_value_ones;
  logic [3:0]   temp_value_tens;
  logic [3:0]   temp_value_huns;
  logic         temp_value_sign;
  logic         ovf;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  temp_bcd_conv #(.W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .value           (value),
    .busy            (busy),
    .done            (done),
    .temp_value_ones (temp_value_ones),
    .temp_value_tens (temp_value_tens),
    .temp_value_huns (temp_value_huns),
    .temp_value_sign (temp_value_sign),
    .ovf             (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal arithmetic on the signed sample
  task automatic expect_out(input string tag, input int v);
    int mag;
    int m;
    int o;
    mag = (v < 0) ? -v : v;
`ifdef TEMP_CONV_SAT_EN
    if (mag > 999) begin m = 999; o = 1; end
    else begin m = mag; o = 0; end
`else
    m = mag % 1000;
    o = 0;
`endif
    chk({tag, ".huns"}, 32'(temp_value_huns), m / 100);
    chk({tag, ".tens"}, 32'(temp_value_tens), (m / 10) % 10);
    chk({tag, ".ones"}, 32'(temp_value_ones), m % 10);
    chk({tag, ".sign"}, 32'(temp_value_sign), (v < 0) ? 1 : 0);
    chk({tag, ".ovf"},  32'(ovf), o);
  endtask

  task automatic convert(input string tag, input int v);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    value = W'(v);
    @(posedge clk);
    #1;
    chk({tag, ".busy_edge0"}, 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk({tag, ".busy_rise"}, 32'(busy), 1);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, ".latency"}, n, W + 2);
    expect_out(tag, v);
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, 32'(done), 0);
    chk({tag, ".busy_drop"}, 32'(busy), 0);
  endtask

  initial begin
    int d0;
    int n;
    int v;
    bit seen;

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    expect_out("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    convert("zero", 0);
    convert("p123", 123);
    convert("n456", -456);
    convert("p1000", 1000);
    convert("n1024", -1024);
    convert("p999", 999);
    convert("n1", -1);
    convert("p1023", 1023);

    // Second request mid-conversion must be dropped
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    value = W'(7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    value = W'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 10) @(negedge clk);
    chk("ignore.done_count", done_cnt - d0, 1);
    expect_out("ignore", 7);
    chk("ignore.busy", 32'(busy), 0);

    // Reset at edge 6 aborts the conversion
    @(negedge clk);
    start = 1'b1;
    value = W'(999);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    d0  = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 6) @(negedge clk);
    chk("abort.done_count", done_cnt - d0, 0);
    chk("abort.busy", 32'(busy), 0);
    expect_out("abort", 0);
    convert("after_rst", 42);

    // Start coincident with reset is dropped
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    value = W'(5);
    d0    = done_cnt;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (W + 6) @(negedge clk);
    chk("rst_start.done_count", done_cnt - d0, 0);
    chk("rst_start.busy", 32'(busy), 0);

    // Back-to-back sweep with start held high
    @(negedge clk);
    value = W'(-999);
    start = 1'b1;
    for (int s = -999; s <= 999; s += 37) begin
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(posedge clk);
        #1;
        n++;
        if (done === 1'b1) seen = 1'b1;
      end
      chk("sweep.period", n, W + 3);
      chk("sweep.valid", 32'((temp_value_huns <= 4'd9) && (temp_value_tens <= 4'd9) &&
                             (temp_value_ones <= 4'd9)), 1);
      expect_out("sweep", s);
      @(negedge clk);
      if (s + 37 <= 999) value = W'(s + 37);
      else start = 1'b0;
    end
    repeat (W + 6) @(negedge clk);
    chk("sweep.idle_busy", 32'(busy), 0);

    // Randomized samples over the full signed range
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 2047));
      if (v >= 1024) v = v - 2048;
      convert("rand", v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
